mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one WIDTH x WIDTH unsigned multiplier between NUM_REQ requesters (p-bit update units).
- Round-robin arbitration, valid/ready handshake on each request port.
- Single outstanding operation; the result returns on one shared response channel tagged with the requester ID.
- Product is truncated to WIDTH bits, modulo 2^WIDTH, plus an overflow flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand and result width in bits.
- LATENCY, 1, multiply cycles spent in BUSY (>=1). Models a registered or pipelined multiplier.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  request pending, bit i = requester i.
- req_ready  output  NUM_REQ  one-hot grant/accept, bit i = requester i.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH : i*WIDTH+WIDTH-1]; bit 0 of each field is the MSB.
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  (a*b) mod 2^WIDTH; bit 0 is the MSB.
- rsp_ovf  output  1  1 when the full 2*WIDTH product >= 2^WIDTH.
- rsp_id  output  clog2(NUM_REQ) (min 1)  index of the requester that owns the result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_id=0, busy=0.
  - Reset applies immediately mid-operation. The in-flight operation is discarded and no response is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid at or after the rr pointer, wrapping modulo NUM_REQ. It is 0 if no req_valid is asserted.
  - On the clock edge with a grant g:
    - latch the a/b fields of requester g and latch g;
    - rr pointer <= (g+1) mod NUM_REQ;
    - load cnt=LATENCY-1;
    - go to BUSY.
  - With no request, stay in IDLE; the pointer is unchanged.
- BUSY:
  - req_ready=0.
  - cnt decrements each cycle. When cnt==0, register the result: rsp_data = low WIDTH bits of the full product, rsp_ovf = (high WIDTH bits != 0), rsp_id = g.
  - Go to RESP on that same edge.
  - BUSY lasts exactly LATENCY cycles.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_data, rsp_ovf and rsp_id hold stable until the handshake.
  - When rsp_valid & rsp_ready on an edge, go to IDLE. rsp_valid drops the next cycle; rsp_data/rsp_ovf/rsp_id keep their last values.
- Latency: from the request-accept edge to rsp_valid high is LATENCY+1 cycles... precisely, rsp_valid is first high in the cycle after BUSY ends. Minimum issue interval is LATENCY+2 cycles.
- Requester rules:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - Dropping req_valid before the grant is legal; that request is simply not serviced.
- Fairness:
  - All requesters held asserted are granted in order 0,1,2,3,0,...
  - A continuously asserting requester waits at most NUM_REQ-1 other grants.
- Arithmetic:
  - Unsigned only.
  - The full product is 2*WIDTH bits internally; only the result is truncated.
- Boundaries:
  - Simultaneous req_valid on all ports: exactly one grant per IDLE cycle.
  - rsp_ready tied high: the RESP state lasts exactly one cycle.
  - rsp_ready held low: the block stalls in RESP indefinitely with no new grants.
  - New requests arriving in BUSY/RESP are not granted until IDLE.

Test Plan:
1. Reset/idle: rst_n=0 then 1, no requests -> all outputs 0 and busy=0 for 10 cycles.
2. Single op, LATENCY=1: req 2 with a=3, b=5 -> req_ready=0100 in the accept cycle; rsp_valid 2 cycles later with rsp_data=15 (1111), rsp_ovf=0, rsp_id=2.
3. Overflow: a=7, b=6 (product 42) -> rsp_data=10, rsp_ovf=1. Also a=15, b=15 -> rsp_data=1, rsp_ovf=1. Also a=0, b=15 -> rsp_data=0, rsp_ovf=0.
4. Round-robin: all 4 req_valid held with distinct operands, rsp_ready=1 -> grants in order 0,1,2,3,0, each spaced LATENCY+2 cycles, and each rsp_id matches its requester's product.
5. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable and req_ready stays 0. Raising rsp_ready gives one handshake, then return to IDLE and a new grant.
6. Reset mid-operation: assert rst_n=0 during BUSY with LATENCY=3 -> outputs clear asynchronously, no rsp_valid after release, rr pointer=0 (requester 0 wins the next contention).

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle for the shared multiplier arbiter.
// Operand fields and rsp_data are MSB-first: the lowest bit index of each field is its MSB.
interface mult_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_ovf;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  // Requesters and the response consumer
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id, busy
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH x WIDTH unsigned multiplier between
// NUM_REQ requesters, one operation in flight, tagged response channel.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);
  localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q;
  logic [ID_W-1:0]    rr_q;
  logic [ID_W-1:0]    id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_ovf_q;
  logic [ID_W-1:0]    rsp_id_q;

  logic [NUM_REQ-1:0] rot_c;
  logic               gnt_vld_c;
  logic [ID_W-1:0]    gnt_id_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [WIDTH-1:0]   a_fld_c [NUM_REQ];
  logic [WIDTH-1:0]   b_fld_c [NUM_REQ];
  logic [PROD_W-1:0]  prod_c;

  // Converts between MSB-at-index-0 bus fields and ordinary numeric vectors
  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      r[k] = x[WIDTH-1-k];
    end
    return r;
  endfunction

  // Unpack per-requester operands into numeric form
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_fld_c[i] = bitrev(bus.req_a[i*WIDTH +: WIDTH]);
      b_fld_c[i] = bitrev(bus.req_b[i*WIDTH +: WIDTH]);
    end
  end

  // Round-robin pick: first valid at or after rr_q, wrapping
  always_comb begin
    rot_c     = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_q);
    gnt_vld_c = 1'b0;
    gnt_id_c  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld_c && rot_c[k]) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = ID_W'((32'(rr_q) + k) % NUM_REQ);
      end
    end
    gnt_c = gnt_vld_c ? (NUM_REQ'(1) << gnt_id_c) : '0;
  end

  // Full-width product; truncation only happens when the result is registered
  assign prod_c = PROD_W'(a_q) * PROD_W'(b_q);

  // Grant is only offered while idle and out of reset
  assign bus.req_ready = (rst_n && state_q == ST_IDLE) ? gnt_c : '0;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_id    = rsp_id_q;

  // Control FSM with operand capture and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld_c) begin
            a_q     <= a_fld_c[gnt_id_c];
            b_q     <= b_fld_c[gnt_id_c];
            id_q    <= gnt_id_c;
            rr_q    <= ID_W'((32'(gnt_id_c) + 32'd1) % NUM_REQ);
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            rsp_data_q <= bitrev(prod_c[WIDTH-1:0]);
            rsp_ovf_q  <= |prod_c[PROD_W-1:WIDTH];
            rsp_id_q   <= id_q;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: a LATENCY=1 instance for the main
// traffic and a LATENCY=3 instance for the mid-operation reset scenario.
module tb_mult_share_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned W  = 4;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst3_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic            rsp_ready;

  int n_vec;
  int n_err;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1;
  exp_t e3;

  mult_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus1 ();
  mult_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus3 ();

  assign bus1.req_valid = req_valid;
  assign bus1.req_a     = req_a;
  assign bus1.req_b     = req_b;
  assign bus1.rsp_ready = rsp_ready;
  assign bus3.req_valid = req_valid;
  assign bus3.req_a     = req_a;
  assign bus3.req_b     = req_b;
  assign bus3.rsp_ready = rsp_ready;

  mult_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  mult_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = x[W-1-k];
    return r;
  endfunction

  function automatic logic [31:0] outs1();
    return 32'({bus1.req_ready, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf, bus1.rsp_id, bus1.busy});
  endfunction

  function automatic logic [31:0] outs3();
    return 32'({bus3.req_ready, bus3.rsp_valid, bus3.rsp_data, bus3.rsp_ovf, bus3.rsp_id, bus3.busy});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = rev(a);
    req_b[i*W +: W] = rev(b);
  endtask

  // Waits (bounded) for rsp_valid on the selected instance; n counts negedges
  task automatic wait_rsp(input bit sel, output int n);
    logic v;
    n = 0;
    v = 1'b0;
    while (!v && n < 20) begin
      @(negedge clk);
      n++;
      v = sel ? bus3.rsp_valid : bus1.rsp_valid;
    end
    if (!v) chk("rsp_timeout", 32'(v), 32'd1);
  endtask

  // Single request on the LATENCY=1 instance with rsp_ready high
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] d, input logic o);
    int n;
    set_op(i, a, b);
    req_valid = NR'(1) << i;
    q1.push_back('{id: 2'(i), data: d, ovf: o});
    @(negedge clk);
    chk("grant_onehot", 32'(bus1.req_ready), 32'(NR'(1) << i));
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1'b0, n);
    chk("latency1", 32'(n), 32'd2);
    @(posedge clk); #1;
  endtask

  // Response scoreboard, LATENCY=1 instance
  always @(negedge clk) begin
    if (rst_n && bus1.rsp_valid && bus1.rsp_ready) begin
      if (q1.size() == 0) begin
        chk("unexpected_rsp1", 32'(bus1.rsp_id), 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        chk("rsp1_id", 32'(bus1.rsp_id), 32'(e1.id));
        chk("rsp1_data", 32'(rev(bus1.rsp_data)), 32'(e1.data));
        chk("rsp1_ovf", 32'(bus1.rsp_ovf), 32'(e1.ovf));
      end
    end
  end

  // Response scoreboard, LATENCY=3 instance
  always @(negedge clk) begin
    if (rst3_n && bus3.rsp_valid && bus3.rsp_ready) begin
      if (q3.size() == 0) begin
        chk("unexpected_rsp3", 32'(bus3.rsp_id), 32'hFFFF_FFFF);
      end else begin
        e3 = q3.pop_front();
        chk("rsp3_id", 32'(bus3.rsp_id), 32'(e3.id));
        chk("rsp3_data", 32'(rev(bus3.rsp_data)), 32'(e3.data));
        chk("rsp3_ovf", 32'(bus3.rsp_ovf), 32'(e3.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int last;
    int g;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    rst3_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;

    // Reset / idle
    #3;
    chk("reset_outs", outs1(), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_outs", outs1(), 32'd0);
    end
    @(posedge clk); #1;

    // Single op: 3*5 = 15
    issue(2, 4'd3, 4'd5, 4'd15, 1'b0);

    // Overflow/boundary products; last grant is 3 so the pointer returns to 0
    issue(0, 4'd0, 4'd15, 4'd0, 1'b0);
    issue(1, 4'd7, 4'd6, 4'd10, 1'b1);
    issue(3, 4'd15, 4'd15, 4'd1, 1'b1);

    // Round robin with all requesters held
    set_op(0, 4'd2, 4'd3);
    set_op(1, 4'd4, 4'd4);
    set_op(2, 4'd5, 4'd3);
    set_op(3, 4'd9, 4'd2);
    q1.push_back('{id: 2'd0, data: 4'd6,  ovf: 1'b0});
    q1.push_back('{id: 2'd1, data: 4'd0,  ovf: 1'b1});
    q1.push_back('{id: 2'd2, data: 4'd15, ovf: 1'b0});
    q1.push_back('{id: 2'd3, data: 4'd2,  ovf: 1'b1});
    q1.push_back('{id: 2'd0, data: 4'd6,  ovf: 1'b0});
    req_valid = 4'hF;
    cyc = 0;
    last = -1;
    g = 0;
    while (g < 5 && cyc < 40) begin
      @(negedge clk);
      if (bus1.req_ready != '0) begin
        chk("rr_grant", 32'(bus1.req_ready), 32'(NR'(1) << (g % 4)));
        if (last >= 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        g++;
      end
      cyc++;
    end
    chk("rr_grant_count", 32'(g), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    cyc = 0;
    while (q1.size() != 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("rr_drain", 32'(q1.size()), 32'd0);
    @(posedge clk); #1;

    // Backpressure: stall in RESP, competing request must wait
    rsp_ready = 1'b0;
    set_op(1, 4'd3, 4'd4);
    req_valid = 4'b0010;
    q1.push_back('{id: 2'd1, data: 4'd12, ovf: 1'b0});
    @(negedge clk);
    chk("bp_grant", 32'(bus1.req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1'b0, n);
    set_op(0, 4'd1, 4'd1);
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", 32'(bus1.rsp_valid), 32'd1);
      chk("bp_data", 32'(rev(bus1.rsp_data)), 32'd12);
      chk("bp_id", 32'(bus1.rsp_id), 32'd1);
      chk("bp_ready", 32'(bus1.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    q1.push_back('{id: 2'd0, data: 4'd1, ovf: 1'b0});
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_grant", 32'(bus1.req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1'b0, n);
    @(posedge clk); #1;
    chk("bp_queue_empty", 32'(q1.size()), 32'd0);

    // Mid-operation reset on the LATENCY=3 instance
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    set_op(2, 4'd5, 4'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mr_grant", 32'(bus3.req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mr_busy", 32'(bus3.busy), 32'd1);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("mr_async_clear", outs3(), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mr_no_rsp", 32'({bus3.rsp_valid, bus3.busy}), 32'd0);
    end
    @(posedge clk); #1;
    set_op(0, 4'd2, 4'd3);
    req_valid = 4'hF;
    q3.push_back('{id: 2'd0, data: 4'd6, ovf: 1'b0});
    @(negedge clk);
    chk("mr_ptr_reset", 32'(bus3.req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1'b1, n);
    chk("latency3", 32'(n), 32'd4);
    @(posedge clk); #1;
    chk("mr_queue_empty", 32'(q3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
